// File: rtl/cordic_pipeline.sv
// cordic_pipeline: fully pipelined rotation-mode CORDIC, one sample per clock.
// Latency STAGES+2: quadrant pre-rotation, STAGES micro-rotations, saturating output.
module cordic_pipeline #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 15,
    parameter int GUARD  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic        [WIDTH-1:0] angle,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] theta,
    output logic                    done
);
    localparam int XW = WIDTH + 2;
    localparam int ZW = WIDTH + GUARD + 1;
    localparam logic signed [XW-1:0] LIM = XW'(2 ** (WIDTH - 1) - 1);
    // atan(2^-i) in units of 2^19 per full turn (GUARD = 4), rescaled below for other guards
    localparam int ATAN [0:17] = '{65536, 38688, 20442, 10377, 5208, 2607, 1304, 652, 326,
                                   163, 81, 41, 20, 10, 5, 3, 1, 1};

    function automatic logic signed [ZW-1:0] atan_step(input int i);
        int v;
        v = (i < 18) ? ATAN[i[4:0]] : 0;
        if (GUARD > 4) v = v <<< (GUARD - 4);
        else if (GUARD < 4) v = (v + (1 <<< (3 - GUARD))) >>> (4 - GUARD);
        return ZW'(v);
    endfunction

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
        return v > LIM ? WIDTH'(LIM) : v < -LIM ? WIDTH'(-LIM) : WIDTH'(v);
    endfunction

    logic signed [XW-1:0] xs [0:STAGES];
    logic signed [XW-1:0] ys [0:STAGES];
    logic signed [ZW-1:0] zs [0:STAGES];
    logic [STAGES:0]      vs;

    logic [WIDTH-2:0]     ph;
    logic [1:0]           q;
    logic signed [XW-1:0] xe, ye, x0, y0;
    logic signed [ZW-1:0] z0;

    assign ph = (WIDTH-1)'(angle);
    assign q  = ph[WIDTH-2:WIDTH-3];
    assign xe = XW'(x_in);
    assign ye = XW'(y_in);
    // widened before negation so -(-32768) is representable
    assign x0 = q == 2'd0 ? xe : q == 2'd1 ? -ye : q == 2'd2 ? -xe : ye;
    assign y0 = q == 2'd0 ? ye : q == 2'd1 ? xe  : q == 2'd2 ? -ye : -xe;
    assign z0 = ZW'({ph[WIDTH-4:0], {GUARD{1'b0}}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs[0] <= '0;
            ys[0] <= '0;
            zs[0] <= '0;
            vs[0] <= 1'b0;
        end else begin
            xs[0] <= x0;
            ys[0] <= y0;
            zs[0] <= z0;
            vs[0] <= en;
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                xs[i+1] <= '0;
                ys[i+1] <= '0;
                zs[i+1] <= '0;
                vs[i+1] <= 1'b0;
            end else begin
                xs[i+1] <= zs[i][ZW-1] ? xs[i] + (ys[i] >>> i) : xs[i] - (ys[i] >>> i);
                ys[i+1] <= zs[i][ZW-1] ? ys[i] - (xs[i] >>> i) : ys[i] + (xs[i] >>> i);
                zs[i+1] <= zs[i][ZW-1] ? zs[i] + atan_step(i) : zs[i] - atan_step(i);
                vs[i+1] <= vs[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_out <= '0;
            y_out <= '0;
            theta <= '0;
            done  <= 1'b0;
        end else begin
            x_out <= sat(xs[STAGES]);
            y_out <= sat(ys[STAGES]);
            theta <= WIDTH'(zs[STAGES] >>> GUARD);
            done  <= vs[STAGES];
        end
    end
endmodule

// File: tb/tb_cordic_pipeline.sv
// tb_cordic_pipeline: random and directed stimulus against a floating-point rotation model
// (ideal rotation times the CORDIC gain, clipped), checked every cycle including done.
module tb_cordic_pipeline;
    localparam int LAT = 17;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0, rst_n = 1'b1, en = 1'b0;
    logic [15:0] angle = '0;
    logic signed [15:0] x_in = '0, y_in = '0;
    logic signed [15:0] x_out, y_out, theta;
    logic done;

    typedef struct {bit v; int a; int x; int y;} samp_t;
    samp_t pipe[$];
    int checks = 0, errors = 0;
    real kgain;

    cordic_pipeline dut (
        .clk(clk), .rst_n(rst_n), .en(en), .angle(angle), .x_in(x_in), .y_in(y_in),
        .x_out(x_out), .y_out(y_out), .theta(theta), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp, input int tol);
        checks++;
        if (got > exp + tol || got < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int clip(input real v);
        int r;
        r = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
        return r > 32767 ? 32767 : r < -32767 ? -32767 : r;
    endfunction

    // sample outputs for the input driven LAT negedges ago, then drive the next input
    task automatic step(input bit v, input int a, input int x, input int y);
        samp_t e, n;
        real p, c, s;
        @(negedge clk);
        e = pipe.pop_front();
        check("done", int'(done), int'(e.v), 0);
        if (e.v) begin
            p = real'(e.a & 32767) / 32768.0 * 2.0 * PI;
            c = $cos(p);
            s = $sin(p);
            check($sformatf("x_out@a=%0d,x=%0d,y=%0d", e.a, e.x, e.y), int'(x_out),
                  clip(kgain * (e.x * c - e.y * s)), 12);
            check($sformatf("y_out@a=%0d,x=%0d,y=%0d", e.a, e.x, e.y), int'(y_out),
                  clip(kgain * (e.x * s + e.y * c)), 12);
            check($sformatf("theta@a=%0d", e.a), int'(theta), 0, 2);
        end
        en = v;
        angle = a[15:0];
        x_in = x[15:0];
        y_in = y[15:0];
        n = '{v: v, a: a, x: x, y: y};
        pipe.push_back(n);
    endtask

    task automatic do_reset();
        samp_t z;
        #2 rst_n = 1'b0;
        #1;
        check("rst_x_out", int'(x_out), 0, 0);
        check("rst_y_out", int'(y_out), 0, 0);
        check("rst_theta", int'(theta), 0, 0);
        check("rst_done", int'(done), 0, 0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        z = '{v: 1'b0, a: 0, x: 0, y: 0};
        pipe.delete();
        repeat (LAT) pipe.push_back(z);
    endtask

    int fa [11] = '{0, 455, 8192, 22755, 29126, 40960, 0, 0, 0, 16384, 16384};
    int fx [11] = '{19895, 19895, 19895, 19895, 19895, 19895, 0, 32767, -32768, 0, -32768};
    int fy [11] = '{0, 0, 0, 0, 0, 0, 19895, 0, 0, 32767, -32768};

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        kgain = 1.0;
        for (int i = 0; i < 15; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2 * i));
        do_reset();
        for (int i = 0; i < 11; i++) begin
            step(1'b1, fa[i], fx[i], fy[i]);
            step(1'b0, 0, 0, 0);
        end
        repeat (LAT + 2) step(1'b0, 0, 0, 0);
        repeat (300) step($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)), 19895, 0);
        repeat (300) step(1'b1, int'($urandom_range(0, 65535)),
                          int'($urandom_range(0, 26000)) - 13000, int'($urandom_range(0, 26000)) - 13000);
        repeat (LAT + 2) step(1'b0, 0, 0, 0);
        for (int a = 0; a < 65536; a += 5) step(1'b1, a, 19895, 0);
        repeat (LAT + 3) step(1'b0, 0, 0, 0);
        for (int a = 0; a < 200; a += 5) step(1'b1, a, 19895, 0);
        do_reset();
        for (int a = 1000; a < 1150; a += 5) step(1'b1, a, 19895, 0);
        repeat (LAT + 2) step(1'b0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
